// File: rtl/tw_status_pkg.sv
// Shared encodings for the TraceWhisperer status/trigger block: LED channel
// modes and trigger-conditioning FSM states.
package tw_status_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_STEADY  = 2'b01,
    LED_STRETCH = 2'b10,
    LED_HB      = 2'b11
  } led_mode_e;

  typedef enum logic {
    TRG_IDLE  = 1'b0,
    TRG_PULSE = 1'b1
  } trg_state_e;

endpackage

// File: rtl/tw_status_ctrl_if.sv
// Control/status bundle between the TraceWhisperer top level (master) and the
// status/trigger-conditioning block (slave).
interface tw_status_ctrl_if #(
  parameter int pLEDS          = 3,
  parameter int pSTRETCH_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 16
);
  logic [pLEDS-1:0]          led_src;
  logic [2*pLEDS-1:0]        led_mode;
  logic [pSTRETCH_WIDTH-1:0] stretch_len;
  logic                      trig_in;
  logic [pSTRETCH_WIDTH-1:0] trig_min_width;
  logic                      quiet;
  logic                      count_clear;
  logic [pLEDS-1:0]          leds;
  logic                      heartbeat;
  logic                      trig_out;
  logic                      mcx_trig;
  logic [pCOUNT_WIDTH-1:0]   trig_count;

  modport master (
    output led_src, led_mode, stretch_len, trig_in, trig_min_width, quiet, count_clear,
    input  leds, heartbeat, trig_out, mcx_trig, trig_count
  );

  modport slave (
    input  led_src, led_mode, stretch_len, trig_in, trig_min_width, quiet, count_clear,
    output leds, heartbeat, trig_out, mcx_trig, trig_count
  );
endinterface

// File: rtl/tw_led_chan.sv
// One LED channel: mode mux (off / steady / retriggerable stretch / heartbeat)
// with a registered LED drive.
module tw_led_chan
  import tw_status_pkg::*;
#(
  parameter int pSTRETCH_WIDTH = 16
) (
  input  logic                      trace_clk,
  input  logic                      reset,
  input  led_mode_e                 mode,
  input  logic                      src,
  input  logic                      hb_next,
  input  logic [pSTRETCH_WIDTH-1:0] stretch_len,
  output logic                      led
);

  localparam logic [pSTRETCH_WIDTH-1:0] STRETCH_ONE = 1;

  logic                      src_q;
  logic [pSTRETCH_WIDTH-1:0] cnt;
  logic [pSTRETCH_WIDTH-1:0] cnt_next;
  logic                      led_next;

  // The counter is only live in STRETCH mode, so any other mode clears it.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    cnt_next = '0;
    led_next = 1'b0;
    unique case (mode)
      LED_OFF:    led_next = 1'b0;
      LED_STEADY: led_next = src;
      LED_STRETCH: begin
        if (src & ~src_q)   cnt_next = stretch_len;
        else if (cnt != '0) cnt_next = cnt - STRETCH_ONE;
        led_next = (cnt_next != '0);
      end
      LED_HB:     led_next = hb_next;
      default:    led_next = 1'b0;
    endcase
  end

  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      src_q <= 1'b0;
      cnt   <= '0;
      led   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      src_q <= src;
      cnt   <= cnt_next;
      led   <= led_next;
    end
  end

endmodule

// File: rtl/tw_status_ctrl.sv
// TraceWhisperer status block: heartbeat, per-LED mode channels, minimum-width
// trigger conditioning and a saturating trigger-event counter on trace_clk.
module tw_status_ctrl
  import tw_status_pkg::*;
#(
  parameter int pLEDS          = 3,
  parameter int pHB_WIDTH      = 23,
  parameter int pSTRETCH_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 16
) (
  input  logic            trace_clk,
  input  logic            reset,
  tw_status_ctrl_if.slave bus
);

  localparam logic [pHB_WIDTH-1:0]      HB_ONE  = 1;
  localparam logic [pSTRETCH_WIDTH-1:0] W_ONE   = 1;
  localparam logic [pCOUNT_WIDTH-1:0]   CNT_ONE = 1;
  localparam logic [pCOUNT_WIDTH-1:0]   CNT_MAX = '1;

  logic                      trig_in_q;
  logic                      trig_rise;
  logic                      freeze;
  logic [pHB_WIDTH-1:0]      hb_cnt;
  logic [pHB_WIDTH-1:0]      hb_next;
  logic                      heartbeat_q;
  trg_state_e                state;
  logic [pSTRETCH_WIDTH-1:0] wcnt;
  logic                      trig_out_q;
  logic [pCOUNT_WIDTH-1:0]   trig_count_q;
  logic [pLEDS-1:0]          leds_q;

  assign trig_rise = bus.trig_in & ~trig_in_q;
  // Heartbeat is frozen while a conditioned trigger is out to keep capture quiet.
  assign freeze    = bus.quiet & trig_out_q;
  assign hb_next   = freeze ? hb_cnt : hb_cnt + HB_ONE;

  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      trig_in_q    <= 1'b0;
      hb_cnt       <= '0;
      heartbeat_q  <= 1'b0;
      trig_count_q <= '0;
    end else begin
      trig_in_q   <= bus.trig_in;
      hb_cnt      <= hb_next;
      heartbeat_q <= hb_next[pHB_WIDTH-1];
      if (bus.count_clear)
        trig_count_q <= '0;
      else if (trig_rise && trig_count_q != CNT_MAX)
        trig_count_q <= trig_count_q + CNT_ONE;
    end
  end

  // Trigger conditioning: passthrough when min width is 0, otherwise a
  // non-retriggerable pulse stretched to at least trig_min_width cycles.
  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      state      <= TRG_IDLE;
      wcnt       <= '0;
      trig_out_q <= 1'b0;
    end else begin
      unique case (state)
        TRG_IDLE: begin
          if (bus.trig_min_width == '0) begin
            trig_out_q <= bus.trig_in;
          end else if (trig_rise) begin
            state      <= TRG_PULSE;
            trig_out_q <= 1'b1;
            wcnt       <= bus.trig_min_width - W_ONE;
          end else begin
            trig_out_q <= 1'b0;
          end
        end
        TRG_PULSE: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - W_ONE;
          end else if (!bus.trig_in) begin
            state      <= TRG_IDLE;
            trig_out_q <= 1'b0;
          end
        end
        default: begin
          state      <= TRG_IDLE;
          trig_out_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < pLEDS; i++) begin : g_led
    tw_led_chan #(
      .pSTRETCH_WIDTH(pSTRETCH_WIDTH)
    ) u_led_chan (
      .trace_clk  (trace_clk),
      .reset      (reset),
      .mode       (led_mode_e'(bus.led_mode[2*i +: 2])),
      .src        (bus.led_src[i]),
      .hb_next    (hb_next[pHB_WIDTH-1]),
      .stretch_len(bus.stretch_len),
      .led        (leds_q[i])
    );
  end

  assign bus.leds       = leds_q;
  assign bus.heartbeat  = heartbeat_q;
  assign bus.trig_out   = trig_out_q;
  assign bus.mcx_trig   = trig_out_q;
  assign bus.trig_count = trig_count_q;

endmodule

// File: tb/tb_tw_status_ctrl.sv
// Self-checking bench for tw_status_ctrl: vector table with an expected-value
// queue, plus directed multi-cycle sequences for pulses, saturation and reset.
module tb_tw_status_ctrl;
  import tw_status_pkg::*;

  localparam int LEDS = 3;
  localparam int HBW  = 8;
  localparam int SW   = 16;
  localparam int CW   = 4;

  logic trace_clk = 1'b0;
  logic reset;
  always #5 trace_clk = ~trace_clk;

  tw_status_ctrl_if #(.pLEDS(LEDS), .pSTRETCH_WIDTH(SW), .pCOUNT_WIDTH(CW)) bus ();

  tw_status_ctrl #(
    .pLEDS(LEDS), .pHB_WIDTH(HBW), .pSTRETCH_WIDTH(SW), .pCOUNT_WIDTH(CW)
  ) dut (
    .trace_clk(trace_clk),
    .reset    (reset),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       trig_in;
    logic [2:0] led_src;
    logic       exp_trig;
    logic [2:0] exp_leds;
  } vec_t;

  typedef struct {
    logic       trig;
    logic [2:0] leds;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge trace_clk);
    #1;
  endtask

  function automatic logic [63:0] ones(input int k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < k; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Hold trig_in for n_in cycles, record trig_out for 40 cycles after the first edge.
  task automatic trig_trace(input int n_in, output logic [39:0] tr);
    tr = '0;
    bus.trig_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      tr[c] = bus.trig_out;
      if (c + 1 == n_in) bus.trig_in = 1'b0;
    end
  endtask

  // Single-cycle led_src[0] pulse, optional retrigger retrig_at cycles later.
  task automatic led_trace(input int retrig_at, output logic [19:0] tr);
    tr = '0;
    bus.led_src[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      tr[c] = bus.leds[0];
      if (c == 0 || c == retrig_at) bus.led_src[0] = 1'b0;
      if (retrig_at > 0 && c + 1 == retrig_at) bus.led_src[0] = 1'b1;
    end
  endtask

  task automatic wait_hb(input int value, output bit found);
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      if (int'(dut.hb_cnt) == value) found = 1'b1;
      else step();
    end
  endtask

  // Fire a width-8 trigger when hb_cnt is 100; report hb_cnt at rise and fall.
  task automatic hb_pulse(input logic q, output int hb_rise, output int hb_fall, output int width);
    bit found;
    bus.quiet = q;
    bus.trig_min_width = 16'd8;
    wait_hb(100, found);
    check("hb_reach_100", found, 1);
    bus.trig_in = 1'b1;
    step();
    hb_rise = int'(dut.hb_cnt);
    bus.trig_in = 1'b0;
    width = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.trig_out == 1'b0) break;
      width++;
    end
    hb_fall = int'(dut.hb_cnt);
    bus.quiet = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] ttr;
    logic [19:0] ltr;
    exp_t e;
    int hr, hf, w;
    bit found;

    vecs[0] = '{1'b1, 3'b001, 1'b1, 3'b001};
    vecs[1] = '{1'b0, 3'b010, 1'b0, 3'b010};
    vecs[2] = '{1'b1, 3'b100, 1'b1, 3'b100};
    vecs[3] = '{1'b1, 3'b111, 1'b1, 3'b111};
    vecs[4] = '{1'b0, 3'b000, 1'b0, 3'b000};
    vecs[5] = '{1'b0, 3'b101, 1'b0, 3'b101};

    reset              = 1'b1;
    bus.led_src        = '0;
    bus.led_mode       = '0;
    bus.stretch_len    = '0;
    bus.trig_in        = 1'b0;
    bus.trig_min_width = '0;
    bus.quiet          = 1'b0;
    bus.count_clear    = 1'b0;
    #12;
    check("rst_trig_out", bus.trig_out, 0);
    check("rst_mcx_trig", bus.mcx_trig, 0);
    check("rst_leds", bus.leds, 0);
    check("rst_count", bus.trig_count, 0);
    check("rst_heartbeat", bus.heartbeat, 0);
    @(posedge trace_clk);
    #1 reset = 1'b0;

    // Passthrough + STEADY vector table through the expected-value queue.
    bus.led_mode = {LED_STEADY, LED_STEADY, LED_STEADY};
    foreach (vecs[i]) begin
      bus.trig_in = vecs[i].trig_in;
      bus.led_src = vecs[i].led_src;
      exp_q.push_back('{vecs[i].exp_trig, vecs[i].exp_leds});
      step();
      e = exp_q.pop_front();
      check($sformatf("vec%0d_trig_out", i), bus.trig_out, e.trig);
      check($sformatf("vec%0d_mcx_trig", i), bus.mcx_trig, e.trig);
      check($sformatf("vec%0d_leds", i), bus.leds, e.leds);
    end
    bus.trig_in = 1'b0;
    bus.led_src = '0;
    step();

    // LED STRETCH: single pulse, retrigger, zero length.
    bus.led_mode    = {LED_OFF, LED_OFF, LED_STRETCH};
    bus.stretch_len = 16'd5;
    led_trace(0, ltr);
    check("stretch_single", ltr, ones(5));
    led_trace(3, ltr);
    check("stretch_retrig", ltr, ones(8));
    bus.stretch_len = 16'd0;
    led_trace(0, ltr);
    check("stretch_zero", ltr, 0);

    // Minimum-width trigger.
    bus.trig_min_width = 16'd4;
    trig_trace(1, ttr);
    check("minw4_short", ttr, ones(4));
    trig_trace(10, ttr);
    check("minw4_long", ttr, ones(10));
    bus.trig_min_width = 16'd1;
    trig_trace(1, ttr);
    check("minw1_short", ttr, ones(1));

    // Counter saturation and clear priority.
    bus.trig_min_width = 16'd0;
    bus.count_clear = 1'b1;
    step();
    bus.count_clear = 1'b0;
    check("count_cleared", bus.trig_count, 0);
    for (int i = 0; i < 20; i++) begin
      bus.trig_in = 1'b1;
      step();
      bus.trig_in = 1'b0;
      step();
      if (i == 6)  check("count_7", bus.trig_count, 7);
      if (i == 14) check("count_15", bus.trig_count, 15);
    end
    check("count_sat", bus.trig_count, 15);
    bus.trig_in = 1'b1;
    bus.count_clear = 1'b1;
    step();
    check("count_clear_prio", bus.trig_count, 0);
    bus.count_clear = 1'b0;
    bus.trig_in = 1'b0;
    step();
    bus.trig_in = 1'b1;
    step();
    check("count_after_clear", bus.trig_count, 1);
    bus.trig_in = 1'b0;
    step();

    // Heartbeat and heartbeat LED mode.
    bus.led_mode = {LED_HB, LED_OFF, LED_OFF};
    wait_hb(127, found);
    check("hb_reach_127", found, 1);
    check("hb_msb_low", bus.heartbeat, 0);
    check("hb_led_low", bus.leds, 3'b000);
    step();
    check("hb_msb_high", bus.heartbeat, 1);
    check("hb_led_high", bus.leds, 3'b100);

    // Quiet freeze versus free-running heartbeat across a width-8 pulse.
    hb_pulse(1'b1, hr, hf, w);
    check("quiet_hb_rise", hr, 101);
    check("quiet_hb_fall", hf, 101);
    check("quiet_width", w, 8);
    hb_pulse(1'b0, hr, hf, w);
    check("free_hb_advance", hf - hr, 8);
    check("free_width", w, 8);

    // Reset two cycles into an 8-cycle pulse.
    bus.led_mode = {LED_STEADY, LED_STEADY, LED_STEADY};
    bus.led_src  = 3'b111;
    bus.trig_min_width = 16'd8;
    step();
    step();
    bus.trig_in = 1'b1;
    step();
    bus.trig_in = 1'b0;
    step();
    check("mid_pulse_trig", bus.trig_out, 1);
    check("mid_pulse_leds", bus.leds, 3'b111);
    #2 reset = 1'b1;
    #1;
    check("async_rst_trig", bus.trig_out, 0);
    check("async_rst_mcx", bus.mcx_trig, 0);
    check("async_rst_leds", bus.leds, 0);
    check("async_rst_count", bus.trig_count, 0);
    @(posedge trace_clk);
    #1 reset = 1'b0;
    trig_trace(1, ttr);
    check("post_rst_pulse", ttr, ones(8));
    check("post_rst_count", bus.trig_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
